// File: rtl/stream_mux_pkg.sv
// Shared constants for the round-robin stream multiplexer: default sizing,
// channel count and the select-mode encodings.
package stream_mux_pkg;

  localparam int unsigned DEF_SEL_W = 2;
  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned CH        = 2**DEF_SEL_W;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef struct packed {
    logic                 vld;
    logic [DEF_SEL_W-1:0] idx;
  } grant_t;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so the pointer sits at
// bit 0, pick the lowest set bit, then rotate the index back.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int SEL_W = DEF_SEL_W,
  localparam int NCH   = 2**SEL_W
) (
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [2*NCH-1:0] req_dbl;
  logic [NCH-1:0]   rot;
  logic [SEL_W-1:0] enc;

  // rotate / priority-encode / un-rotate; the index add wraps modulo NCH
  always_comb begin
    req_dbl = {req, req};
    rot     = req_dbl[ptr +: NCH];
    enc     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        enc = SEL_W'(i);
      end else begin
        enc = enc;
      end
    end
    gnt_idx = enc + ptr;
    gnt_vld = |req;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// 2**SEL_W : 1 valid/ready stream multiplexer with round-robin or fixed
// channel selection and a single registered output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int SEL_W = DEF_SEL_W,
  parameter  int DW    = DEF_DW,
  localparam int NCH   = 2**SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH*DW-1:0]  in_data,
  input  logic [NCH-1:0]     in_valid,
  output logic [NCH-1:0]     in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   fix_sel,
  output logic [DW-1:0]      out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             load_en;
  logic             xfer;
  logic [DW-1:0]    sel_data;

  rr_arbiter #(.SEL_W(SEL_W)) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  // Grant source follows mode within the same cycle; the held beat is untouched.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    case (mode)
      MODE_RR: begin
        gnt_idx = rr_idx;
        gnt_vld = rr_vld;
      end
      MODE_FIXED: begin
        gnt_idx = fix_sel;
        gnt_vld = in_valid[fix_sel];
      end
      default: begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
      end
    endcase
  end

  assign load_en  = !out_valid || out_ready;
  assign xfer     = !rst && load_en && gnt_vld;
  assign sel_data = in_data[gnt_idx*DW +: DW];

  // Only the granted channel may see ready, and only when the stage can load.
  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[gnt_idx] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Output stage and round-robin pointer; a load while draining replaces the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= gnt_idx;
      if (mode == MODE_RR) begin
        ptr <= gnt_idx + SEL_W'(1);
      end else begin
        ptr <= ptr;
      end
    end else if (out_ready && out_valid) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomised and directed bench for stream_mux_rr against a behavioural
// model (scan-order grant, output beat state, beat scoreboard).
module tb_stream_mux_rr;

  localparam int SEL_W = 2;
  localparam int DW    = 8;
  localparam int CH    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH*DW-1:0]  in_data;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic              mode;
  logic [SEL_W-1:0]  fix_sel;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  out_sel;

  stream_mux_rr #(.SEL_W(SEL_W), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .fix_sel   (fix_sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  logic        m_valid;
  logic [7:0]  m_data;
  int          m_sel;
  int          m_ptr;
  int          beat_q[$];
  logic [CH-1:0] last_rdy;
  int          hs_a5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant from the arbitration rules: fixed channel, or first requester from ptr onward.
  function automatic int grant_of();
    if (mode) begin
      return in_valid[fix_sel] ? int'(fix_sel) : -1;
    end
    for (int k = 0; k < CH; k++) begin
      if (in_valid[(m_ptr + k) % CH]) return (m_ptr + k) % CH;
    end
    return -1;
  endfunction

  // One cycle: check outputs, score handshakes, advance model across the edge.
  task automatic step();
    int g;
    int e;
    logic [CH-1:0] exp_rdy;
    bit load;
    #1;
    check("out_valid", out_valid, m_valid);
    check("out_sel", out_sel, m_sel);
    check("out_data", out_data, m_data);
    g = grant_of();
    load = !m_valid || out_ready;
    exp_rdy = '0;
    if (!rst && load && g >= 0) exp_rdy[g] = 1'b1;
    check("in_ready", in_ready, exp_rdy);
    last_rdy = in_ready;
    if (rst) begin
      beat_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (out_data == 8'hA5) hs_a5++;
        if (beat_q.size() == 0) begin
          check("sb_unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = beat_q.pop_front();
          check("sb_beat", int'({out_sel, out_data}), e);
        end
      end
      if (exp_rdy != '0) beat_q.push_back((g << 8) | int'(in_data[g*DW +: DW]));
    end
    if (rst) begin
      m_valid = 1'b0; m_data = 8'h00; m_sel = 0; m_ptr = 0;
    end else if (exp_rdy != '0) begin
      m_valid = 1'b1;
      m_data  = in_data[g*DW +: DW];
      m_sel   = g;
      if (!mode) m_ptr = (g + 1) % CH;
    end else if (out_ready && m_valid) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'hF; in_data = '0; mode = 1'b0; fix_sel = '0; out_ready = 1'b0;
    hs_a5 = 0;
    m_valid = 1'b0; m_data = 8'h00; m_sel = 0; m_ptr = 0;
    @(posedge clk);
    @(negedge clk);

    // reset held with every channel requesting
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_in_ready", last_rdy, 4'h0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_sel", out_sel, 2'd0);
    end

    // round-robin fairness: 0,1,2,3,0,...
    rst = 1'b0; out_ready = 1'b1;
    in_data = {8'd3, 8'd2, 8'd1, 8'd0};
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_seq_sel", out_sel, i % 4);
      check("rr_seq_data", out_data, i % 4);
      check("rr_seq_valid", out_valid, 1'b1);
    end

    // skip and wrap: move ptr to 1, then only channels 0 and 3 request
    in_valid = 4'b0001;
    step();
    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step();
      check("skip_rdy", last_rdy, (i % 2) ? 4'b0001 : 4'b1000);
      check("skip_sel", out_sel, (i % 2) ? 2'd0 : 2'd3);
    end

    // backpressure on an A5 beat from channel 1
    in_valid = 4'b0010;
    in_data[15:8] = 8'hA5;
    step();
    check("bp_load", out_data, 8'hA5);
    in_valid = 4'hF; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_data", out_data, 8'hA5);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_rdy", last_rdy, 4'h0);
    end
    in_valid = 4'h0; out_ready = 1'b1; hs_a5 = 0;
    for (int i = 0; i < 3; i++) step();
    check("bp_single_hs", hs_a5, 1);

    // fixed mode: only channel 2, then starve it; ptr must stay at 2
    in_data = {8'd3, 8'd2, 8'd1, 8'd0};
    mode = 1'b1; fix_sel = 2'd2; in_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fix_rdy", last_rdy, 4'b0100);
      check("fix_sel_out", out_sel, 2'd2);
    end
    in_valid = 4'b1011;
    step();
    check("fix_starve_rdy", last_rdy, 4'h0);
    check("fix_drain", out_valid, 1'b0);
    mode = 1'b0; in_valid = 4'hF;
    step();
    check("fix_ptr_kept", last_rdy, 4'b0100);

    // mid-operation reset while stalled
    out_ready = 1'b0;
    step();
    check("mr_stalled", out_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_valid_cleared", out_valid, 1'b0);
    out_ready = 1'b1;
    step();
    check("mr_restart_ch0", last_rdy, 4'b0001);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      mode      = ($urandom_range(0, 4) == 0);
      fix_sel   = SEL_W'($urandom_range(0, CH - 1));
      in_valid  = CH'($urandom_range(0, 15));
      in_data   = {$urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
